// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: redirect, instruction-memory and F/D slot signals of the fetch unit.
interface ifu_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_exc;
    logic        id_ready;
    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4, if_exc
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4, if_exc
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch PC owner issuing req/ack imem reads into a one-entry F/D slot.
// Define IFU_ADEL_EN to trap misaligned/out-of-range fetch addresses without touching imem.
module ifu_fetch #(
`ifdef IFU_ADEL_EN
    parameter logic [31:0] ADDR_LO = 32'h0000_3000,
    parameter logic [31:0] ADDR_HI = 32'h0000_6FFC,
`endif
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic         clk,
    input logic         reset,
    ifu_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_redir_hold;
    logic        r_req;
    logic        r_if_valid;
    logic [31:0] w_next_pc;
    logic        w_enter;
    logic        w_ack;
    logic        w_bad;

    // A redirect arriving while no fetch is in flight steers the very next request.
    assign w_next_pc = bus.redirect_valid ? bus.redirect_pc : r_fetch_pc;
    assign w_enter   = (r_state == IDLE) || (r_state == DRAIN && r_if_valid && bus.id_ready);

`ifdef IFU_ADEL_EN
    logic r_fault;
    logic r_if_exc;
    assign w_bad = (w_next_pc[1:0] != 2'b00) || (w_next_pc < ADDR_LO) || (w_next_pc > ADDR_HI);
    // A faulting fetch completes by itself one cycle after entering REQ.
    assign w_ack = r_req ? bus.imem_ack : r_fault;
`else
    assign w_bad = 1'b0;
    assign w_ack = r_req && bus.imem_ack;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_redir_hold <= 1'b0;
            r_req        <= 1'b0;
            r_if_valid   <= 1'b0;
            r_if_instr   <= 32'h0;
            r_if_pc      <= RESET_PC;
`ifdef IFU_ADEL_EN
            r_fault      <= 1'b0;
            r_if_exc     <= 1'b0;
`endif
        end else begin
            r_fetch_pc   <= bus.redirect_valid ? bus.redirect_pc :
                            (w_ack && !r_redir_hold) ? r_req_addr + 32'd4 : r_fetch_pc;
            r_redir_hold <= bus.redirect_valid ? (r_state == REQ && !w_ack) : (r_redir_hold && !w_ack);
            if (w_enter) begin
                r_state    <= REQ;
                r_req_addr <= w_next_pc;
                r_req      <= !w_bad;
                r_if_valid <= 1'b0;
`ifdef IFU_ADEL_EN
                r_fault    <= w_bad;
`endif
            end else if (w_ack) begin
                r_state    <= DRAIN;
                r_req      <= 1'b0;
                r_if_valid <= 1'b1;
                r_if_pc    <= r_req_addr;
`ifdef IFU_ADEL_EN
                r_if_instr <= r_fault ? 32'h0 : bus.imem_rdata;
                r_if_exc   <= r_fault;
                r_fault    <= 1'b0;
`else
                r_if_instr <= bus.imem_rdata;
`endif
            end
        end
    end

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_req_addr;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_pc4    = r_if_pc + 32'd4;
`ifdef IFU_ADEL_EN
    assign bus.if_exc    = r_if_exc;
`else
    assign bus.if_exc    = 1'b0;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: table-driven fetch transactions with a scoreboard of delivered instructions.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef IFU_ADEL_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          lat;
        int          stall;
        logic [31:0] rpc;
        int          at;
        logic [31:0] rpc2;
        int          at2;
        bit          fault;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_err = 0;
    int   n_chk = 0;
    vec_t tv[12];
    exp_t sb[$];

    always #5 clk = ~clk;

    ifu_fetch_if bus();
    ifu_fetch dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input int lat, input int stall,
                                input logic [31:0] rpc = 32'h0, input int at = -1,
                                input logic [31:0] rpc2 = 32'h0, input int at2 = -1,
                                input bit fault = 1'b0);
        vec_t v;
        v.addr = addr; v.lat = lat; v.stall = stall; v.rpc = rpc; v.at = at;
        v.rpc2 = rpc2; v.at2 = at2; v.fault = fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] addr);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.imem_req) seen = 1'b1;
            else step();
        end
        chk("req_seen", {31'h0, seen}, 32'h1);
        chk("imem_addr", bus.imem_addr, addr);
    endtask

    task automatic run(input vec_t e);
        exp_t x;
        if (e.fault) begin
            bus.id_ready = 1'b0;
            chk("fault_no_req", {31'h0, bus.imem_req}, 32'h0);
            sb.push_back('{e.addr, 32'h0, 1'b1});
            for (int i = 0; i < 4 && !bus.if_valid; i++) begin
                step();
                chk("fault_no_req", {31'h0, bus.imem_req}, 32'h0);
            end
        end else begin
            wait_req(e.addr);
            for (int i = 0; i <= e.lat; i++) begin
                bus.redirect_valid = (i == e.at) || (i == e.at2);
                bus.redirect_pc    = (i == e.at2) ? e.rpc2 : e.rpc;
                bus.imem_ack       = (i == e.lat);
                bus.imem_rdata     = mem(bus.imem_addr);
                bus.id_ready       = (i < e.lat) && (i % 2 == 1);
                if (i == e.lat) sb.push_back('{e.addr, mem(e.addr), 1'b0});
                step();
                if (i < e.lat) begin
                    chk("req_held", {31'h0, bus.imem_req}, 32'h1);
                    chk("addr_stable", bus.imem_addr, e.addr);
                end
            end
            bus.imem_ack       = 1'b0;
            bus.redirect_valid = 1'b0;
        end
        chk("slot_valid", {31'h0, bus.if_valid}, 32'h1);
        for (int i = 0; i < e.stall; i++) begin
            bus.imem_ack       = (i == 1);
            bus.imem_rdata     = 32'hBAD0_BAD0;
            bus.redirect_valid = (e.at == 100) && (i == 0);
            bus.redirect_pc    = e.rpc;
            step();
            bus.imem_ack       = 1'b0;
            bus.redirect_valid = 1'b0;
            chk("stall_valid", {31'h0, bus.if_valid}, 32'h1);
            chk("stall_no_req", {31'h0, bus.imem_req}, 32'h0);
            if (sb.size() > 0) chk("stall_instr", bus.if_instr, sb[0].instr);
        end
        bus.id_ready = 1'b1;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: slot at pc %h but no expected entry", bus.if_pc);
        end else begin
            x = sb.pop_front();
            chk("if_pc", bus.if_pc, x.pc);
            chk("if_instr", bus.if_instr, x.instr);
            chk("if_pc4", bus.if_pc4, x.pc + 32'd4);
            chk("if_exc", {31'h0, bus.if_exc}, {31'h0, x.exc});
        end
        step();
        bus.id_ready = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.id_ready       = 1'b0;
        tv[0]  = mk(32'h3000, 1, 4);
        tv[1]  = mk(32'h3004, 1, 0);
        tv[2]  = mk(32'h3008, 5, 0);
        tv[3]  = mk(32'h300C, 2, 0, 32'h3100, 1);
        tv[4]  = mk(32'h3100, 1, 1);
        tv[5]  = mk(32'h3104, 3, 0, 32'h3200, 3);
        tv[6]  = mk(32'h3200, 3, 0, 32'h3300, 0, 32'h3400, 1);
        tv[7]  = mk(32'h3400, 1, 0);
        tv[8]  = mk(32'h3404, 1, 2);
        tv[9]  = mk(32'h3000, 2, 0, 32'h3102, 0);
        tv[10] = mk(32'h3102, 1, 2, 32'h7000, 100, 32'h0, -1, ADEL);
        tv[11] = mk(32'h7000, 1, 0, 32'h0, -1, 32'h0, -1, ADEL);
        step();
        step();
        chk("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_if_pc", bus.if_pc, RESET_PC);
        chk("rst_if_pc4", bus.if_pc4, RESET_PC + 32'd4);
        chk("rst_if_exc", {31'h0, bus.if_exc}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) run(tv[i]);
        wait_req(32'h3408);
        reset = 1'b1;
        #1;
        chk("midreq_rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("midreq_rst_addr", bus.imem_addr, RESET_PC);
        chk("midreq_rst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("midreq_rst_instr", bus.if_instr, 32'h0);
        chk("midreq_rst_pc", bus.if_pc, RESET_PC);
        step();
        reset = 1'b0;
        for (int i = 9; i < 12; i++) run(tv[i]);
        chk("sb_drained", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
